// File: rtl/writeback_unit.sv
// Writeback stage: takes an execute result, waits for load data when needed,
// extracts and extends sub-word loads, and issues one register-bank write.
module writeback_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        stage_clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu_out,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rd,
    output logic [31:0] alu_out,
    output logic        save_to_reg,
    output logic        busy,
    output logic        load_fault
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WRITE    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [REG_W-1:0]    rd_q, rd_d;
    logic [DATA_W-1:0]   alu_out_q, alu_out_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          addr_lo_q, addr_lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                save_q, save_d;
    logic                fault_q, fault_d;

    logic                accept_c;
    logic                load_bad_c;
    logic                timeout_c;

    // Align the addressed byte/half to bit 0 and sign- or zero-extend it.
    function automatic logic [DATA_W-1:0] extract(
        input logic [DATA_W-1:0] word,
        input logic [2:0]        f3,
        input logic [1:0]        lo
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[{lo, 3'b000} +: 8];
        half_v = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extract = {{24{byte_v[7]}}, byte_v};
            3'b001:  extract = {{16{half_v[15]}}, half_v};
            3'b100:  extract = {24'd0, byte_v};
            3'b101:  extract = {16'd0, half_v};
            default: extract = word;
        endcase
    endfunction

    assign in_ready = reset && (state_q == S_IDLE);
    assign accept_c = in_valid && in_ready;
    assign busy     = (state_q != S_IDLE);

    // Illegal funct3 and misaligned accesses share the same fault path.
    always_comb begin
        load_bad_c = 1'b0;
        case (in_funct3)
            3'b000, 3'b100: load_bad_c = 1'b0;
            3'b001, 3'b101: load_bad_c = in_addr_lo[0];
            3'b010:         load_bad_c = (in_addr_lo != 2'b00);
            default:        load_bad_c = 1'b1;
        endcase
    end

    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge stage_clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rd_q      <= '0;
            alu_out_q <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            cnt_q     <= '0;
            save_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            alu_out_q <= alu_out_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            cnt_q     <= cnt_d;
            save_q    <= save_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (!in_is_load)     state_d = S_WRITE;
                    else if (!load_bad_c) state_d = S_WAIT_MEM;
                end
            end
            S_WAIT_MEM: begin
                if (mem_rvalid)     state_d = S_WRITE;
                else if (timeout_c) state_d = S_IDLE;
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and captured fields.
    always_comb begin
        rd_d      = rd_q;
        alu_out_d = alu_out_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        cnt_d     = cnt_q;
        save_d    = 1'b0;
        fault_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    rd_d      = in_rd;
                    funct3_d  = in_funct3;
                    addr_lo_d = in_addr_lo;
                    cnt_d     = '0;
                    if (!in_is_load) begin
                        alu_out_d = in_alu_out;
                        save_d    = (in_rd != '0);
                    end else if (load_bad_c) begin
                        fault_d = 1'b1;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    alu_out_d = extract(mem_rdata, funct3_q, addr_lo_q);
                    save_d    = (rd_q != '0);
                end else if (timeout_c) begin
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign rd          = rd_q;
    assign alu_out     = alu_out_q;
    assign save_to_reg = save_q;
    assign load_fault  = fault_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized scoreboard bench for writeback_unit with a short load timeout.
module tb_writeback_unit;

    localparam int TO = 4;

    logic        stage_clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_out;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
    logic [31:0] alu_out;
    logic        save_to_reg;
    logic        busy;
    logic        load_fault;

    writeback_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .stage_clk  (stage_clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_alu_out (in_alu_out),
        .in_is_load (in_is_load),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rd         (rd),
        .alu_out    (alu_out),
        .save_to_reg(save_to_reg),
        .busy       (busy),
        .load_fault (load_fault)
    );

    typedef struct {
        bit          is_fault;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    initial stage_clk = 1'b0;
    always #5 stage_clk = ~stage_clk;
    always @(posedge stage_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a load result is the addressed unit shifted down and extended.
    function automatic void ref_load(input logic [2:0] f3, input logic [1:0] a,
                                     input logic [31:0] w, output bit bad,
                                     output logic [31:0] d);
        logic [31:0] sh;
        sh  = w >> (int'(a) * 8);
        bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
              ((f3 == 3'd1 || f3 == 3'd5) && a[0]) ||
              (f3 == 3'd2 && a != 2'd0);
        case (f3)
            3'd0:    d = 32'($signed(sh[7:0]));
            3'd1:    d = 32'($signed(sh[15:0]));
            3'd4:    d = sh & 32'h0000_00FF;
            3'd5:    d = sh & 32'h0000_FFFF;
            default: d = w;
        endcase
    endfunction

    // Monitor: every write/fault pulse must match the oldest expectation.
    always @(negedge stage_clk) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
            compared++;
            mismatched++;
            $display("FAIL missed_pulse: no pulse observed by cycle %0d, required at cycle %0d", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (save_to_reg || load_fault) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_pulse: save=%b fault=%b at cycle %0d, required none",
                         save_to_reg, load_fault, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("pulse_kind", {30'd0, save_to_reg, load_fault},
                    mon_e.is_fault ? 32'd1 : 32'd2);
                if (!mon_e.is_fault) begin
                    chk("write_rd", {27'd0, rd}, {27'd0, mon_e.rd});
                    chk("write_data", alu_out, mon_e.data);
                end
            end
        end
    end

    function automatic exp_t mk(input bit f, input logic [4:0] r, input logic [31:0] d, input int c);
        exp_t e;
        e.is_fault = f;
        e.rd       = r;
        e.data     = d;
        e.cyc      = c;
        return e;
    endfunction

    // One transaction; k = edge offset of mem_rvalid after accept (outside 1..TO: none in time).
    task automatic txn(input bit ld, input logic [2:0] f3, input logic [1:0] a,
                       input logic [4:0] rdi, input logic [31:0] alu,
                       input int k, input logic [31:0] w);
        int          n;
        int          waited;
        bit          bad;
        logic [31:0] d;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(posedge stage_clk); #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL ready_wait: in_ready=%b after %0d cycles, required 1", in_ready, waited);
            return;
        end
        in_valid   = 1'b1;
        in_is_load = ld;
        in_funct3  = f3;
        in_addr_lo = a;
        in_rd      = rdi;
        in_alu_out = alu;
        @(posedge stage_clk); #1;
        n          = cyc;
        in_valid   = 1'b0;
        in_rd      = 5'($urandom);
        in_alu_out = $urandom;
        if (!ld) begin
            if (rdi != 5'd0) q.push_back(mk(1'b0, rdi, alu, n));
            chk("ready_in_write", {31'd0, in_ready}, 32'd0);
            chk("busy_in_write", {31'd0, busy}, 32'd1);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            @(posedge stage_clk); #1;
            mem_rvalid = 1'b0;
            chk("ready_after_write", {31'd0, in_ready}, 32'd1);
        end else begin
            ref_load(f3, a, w, bad, d);
            if (bad) begin
                q.push_back(mk(1'b1, 5'd0, 32'd0, n));
                chk("ready_after_bad_load", {31'd0, in_ready}, 32'd1);
            end else if (k >= 1 && k <= TO) begin
                chk("busy_wait_mem", {31'd0, busy}, 32'd1);
                if (rdi != 5'd0) q.push_back(mk(1'b0, rdi, d, n + k));
                mem_rdata = $urandom;
                repeat (k - 1) begin @(posedge stage_clk); #1; end
                mem_rvalid = 1'b1;
                mem_rdata  = w;
                @(posedge stage_clk); #1;
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end else begin
                chk("busy_wait_mem", {31'd0, busy}, 32'd1);
                q.push_back(mk(1'b1, 5'd0, 32'd0, n + TO));
                repeat (TO) begin @(posedge stage_clk); #1; end
                chk("ready_after_timeout", {31'd0, in_ready}, 32'd1);
                if (k > TO) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                    @(posedge stage_clk); #1;
                    mem_rvalid = 1'b0;
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_rd      = '0;
        in_alu_out = '0;
        in_is_load = 1'b0;
        in_funct3  = '0;
        in_addr_lo = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(posedge stage_clk);
        #1;
        chk("reset_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_outputs", {rd, save_to_reg, load_fault}, 32'd0);
        chk("reset_alu_out", alu_out, 32'd0);
        reset = 1'b1;
        #1;
        chk("ready_after_release", {31'd0, in_ready}, 32'd1);

        txn(1'b0, 3'd0, 2'd0, 5'd5, 32'h0000_1234, 0, 32'd0);
        txn(1'b1, 3'b000, 2'b11, 5'd7, 32'h1111_1111, 3, 32'h80FF_0000);
        txn(1'b1, 3'b100, 2'b11, 5'd8, 32'h2222_2222, 3, 32'h80FF_0000);
        txn(1'b1, 3'b001, 2'b10, 5'd9, 32'h0, 2, 32'h8001_7FFF);
        txn(1'b1, 3'b010, 2'b01, 5'd10, 32'h0, 1, 32'hCAFE_F00D);
        txn(1'b1, 3'b110, 2'b00, 5'd11, 32'h0, 1, 32'hCAFE_F00D);
        txn(1'b1, 3'b010, 2'b00, 5'd12, 32'h0, 0, 32'h0);
        txn(1'b1, 3'b010, 2'b00, 5'd13, 32'h0, TO, 32'h1357_9BDF);
        txn(1'b0, 3'd0, 2'd0, 5'd0, 32'hDEAD_BEEF, 0, 32'd0);

        // Reset two cycles into WAIT_MEM, then a stale mem_rvalid.
        while (in_ready !== 1'b1) begin @(posedge stage_clk); #1; end
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = 3'b010;
        in_addr_lo = 2'b00;
        in_rd      = 5'd14;
        @(posedge stage_clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge stage_clk); #1; end
        reset = 1'b0;
        @(posedge stage_clk); #1;
        chk("abort_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_outputs", {rd, save_to_reg, load_fault}, 32'd0);
        chk("abort_alu_out", alu_out, 32'd0);
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(posedge stage_clk); #1;
        mem_rvalid = 1'b0;
        chk("abort_ready_after", {31'd0, in_ready}, 32'd1);
        chk("abort_busy_after", {31'd0, busy}, 32'd0);
        chk("abort_alu_after", alu_out, 32'd0);

        for (int i = 0; i < 300; i++) begin
            txn(1'($urandom_range(0, 1)), 3'($urandom), 2'($urandom), 5'($urandom),
                $urandom, int'($urandom_range(0, 6)), $urandom);
        end

        repeat (8) @(posedge stage_clk);
        #1;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover_expected: %0d pulses outstanding, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
